// File: rtl/opti_sos_sched.sv
// Time-multiplexed sequencer for one shared SOS engine: runs the engine once per
// stage on each sample, chains stage results and holds the programmable coefficient bank.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted here
// ISSUE | loads job registers for the current stage (strobe appears next cycle)
// WAIT  | job in flight; timer counts cycles until eng_done or timeout
// OUT   | final result held on out_data until out_ready
module opti_sos_sched #(
    parameter int NUM_STAGES = 6,
    parameter int DW         = 16,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             eng_start,
    output logic             eng_clear,
    output logic [2:0]       eng_stage,
    output logic [DW-1:0]    eng_x,
    output logic [DW-1:0]    eng_b0,
    output logic [DW-1:0]    eng_b1,
    output logic [DW-1:0]    eng_b2,
    output logic [DW-1:0]    eng_a1,
    output logic [DW-1:0]    eng_a2,
    input  logic             eng_done,
    input  logic [DW-1:0]    eng_y,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sample_cnt,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_stage,
    input  logic [2:0]       cfg_sel,
    input  logic [DW-1:0]    cfg_wdata,
    output logic             cfg_err,
    output logic             timeout_err,
    output logic             busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // 1.0 in Q2.13 (DW-3 fractional bits)
    localparam logic [DW-1:0] UNITY = DW'(1) << (DW - 3);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t          state;
    logic [2:0]      stage;
    logic [DW-1:0]   data_q;
    logic [TW-1:0]   timer;
    logic [DW-1:0]   bank [NUM_STAGES][5];
    logic            cfg_ok;

    assign cfg_ok   = cfg_we && (state == IDLE)
                      && ({1'b0, cfg_stage} < 4'(NUM_STAGES))
                      && (cfg_sel <= 3'd4);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            stage       <= '0;
            data_q      <= '0;
            timer       <= '0;
            sample_cnt  <= '0;
            eng_start   <= 1'b0;
            eng_clear   <= 1'b0;
            eng_stage   <= '0;
            eng_x       <= '0;
            eng_b0      <= '0;
            eng_b1      <= '0;
            eng_b2      <= '0;
            eng_a1      <= '0;
            eng_a2      <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            cfg_err     <= 1'b0;
            timeout_err <= 1'b0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                for (int c = 0; c < 5; c++) begin
                    bank[s][c] <= (c == 0) ? UNITY : '0;
                end
            end
        end else begin
            eng_start   <= 1'b0;
            eng_clear   <= 1'b0;
            cfg_err     <= 1'b0;
            timeout_err <= 1'b0;

            if (cfg_we) begin
                if (cfg_ok) begin
                    bank[cfg_stage][cfg_sel] <= cfg_wdata;
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        eng_clear  <= 1'b1;
                        sample_cnt <= '0;
                    end
                    if (in_valid) begin
                        data_q <= in_data;
                        stage  <= '0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    eng_start <= 1'b1;
                    eng_x     <= data_q;
                    eng_stage <= stage;
                    eng_b0    <= bank[stage][0];
                    eng_b1    <= bank[stage][1];
                    eng_b2    <= bank[stage][2];
                    eng_a1    <= bank[stage][3];
                    eng_a2    <= bank[stage][4];
                    timer     <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // a result arriving on the last allowed cycle still counts
                    if (eng_done) begin
                        data_q <= eng_y;
                        if (stage == 3'(NUM_STAGES - 1)) begin
                            out_data  <= eng_y;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            stage <= stage + 3'd1;
                            state <= ISSUE;
                        end
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        sample_cnt <= sample_cnt + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_opti_sos_sched.sv
// Directed bench for opti_sos_sched with a stub engine and an output scoreboard.
module tb_opti_sos_sched;

    localparam int N  = 6;
    localparam int DW = 16;
    localparam int TO = 64;
    localparam int CW = 11;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          eng_start;
    logic          eng_clear;
    logic [2:0]    eng_stage;
    logic [DW-1:0] eng_x, eng_b0, eng_b1, eng_b2, eng_a1, eng_a2;
    logic          eng_done;
    logic [DW-1:0] eng_y;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] sample_cnt;
    logic          cfg_we;
    logic [2:0]    cfg_stage;
    logic [2:0]    cfg_sel;
    logic [DW-1:0] cfg_wdata;
    logic          cfg_err;
    logic          timeout_err;
    logic          busy;

    logic stub_en, stub_mode, man_done;

    opti_sos_sched #(.NUM_STAGES(N), .DW(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .eng_start(eng_start), .eng_clear(eng_clear), .eng_stage(eng_stage),
        .eng_x(eng_x), .eng_b0(eng_b0), .eng_b1(eng_b1), .eng_b2(eng_b2),
        .eng_a1(eng_a1), .eng_a2(eng_a2), .eng_done(eng_done), .eng_y(eng_y),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sample_cnt(sample_cnt), .cfg_we(cfg_we), .cfg_stage(cfg_stage),
        .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .timeout_err(timeout_err), .busy(busy)
    );

    // stub engine: answers in the strobe cycle; mode 1 adds (1+stage) per job
    assign eng_done = (eng_start & stub_en) | man_done;
    assign eng_y    = stub_mode ? (eng_x + 16'd1 + {13'd0, eng_stage}) : eng_x;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  stage;
        logic [15:0] x, b0, b1, b2, a1, a2;
    } job_t;

    job_t          jobs[$];
    logic [15:0]   exp_q[$];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            acc_cyc = 0;
    int            ov_cyc  = 0;
    logic          ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] x);
        logic [15:0] y;
        y = x;
        if (stub_mode) begin
            for (int k = 0; k < N; k++) y = y + 16'(k + 1);
        end
        return y;
    endfunction

    always @(negedge clk) begin
        job_t j;
        logic [15:0] e;
        if (rst_n && eng_start) begin
            j.stage = eng_stage; j.x = eng_x;
            j.b0 = eng_b0; j.b1 = eng_b1; j.b2 = eng_b2; j.a1 = eng_a1; j.a2 = eng_a2;
            jobs.push_back(j);
        end
        if (rst_n && out_valid && !ov_prev) ov_cyc = cyc;
        ov_prev = out_valid;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_out", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_out_data", out_data, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin step(); n++; end
        chk("send_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = x;
        if (push) exp_q.push_back(model(x));
        step();
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        bit ok;
        while ((busy || exp_q.size() != 0) && n < 400) begin step(); n++; end
        ok = !busy && (exp_q.size() == 0);
        chk(tag, ok, 1'b1);
    endtask

    task automatic cfg_write(input logic [2:0] st, input logic [2:0] sel, input logic [15:0] v);
        cfg_we = 1'b1; cfg_stage = st; cfg_sel = sel; cfg_wdata = v;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        int n;
        bit stable;
        logic [CW-1:0] cnt0;
        logic [15:0] hold_x;

        rst_n = 1'b0; start = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_stage = '0; cfg_sel = '0; cfg_wdata = '0;
        stub_en = 1'b1; stub_mode = 1'b0; man_done = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // reset state
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_eng_start", eng_start, 1'b0);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_eng_b0", eng_b0, 0);

        // start pulse in IDLE
        start = 1'b1; step(); start = 1'b0;
        chk("start_clear", eng_clear, 1'b1);
        step();
        chk("start_clear_end", eng_clear, 1'b0);

        // passthrough run, latency and job sequence
        jobs.delete();
        send(16'h1234, 1'b1);
        wait_idle("t1_idle");
        chk("t1_jobs", jobs.size(), N);
        for (int k = 0; k < N; k++) begin
            chk("t1_stage", jobs[k].stage, k);
            chk("t1_x", jobs[k].x, 16'h1234);
            chk("t1_b0", jobs[k].b0, 16'h2000);
            chk("t1_a2", jobs[k].a2, 16'h0000);
        end
        chk("t1_latency", ov_cyc - acc_cyc, 2 * N);
        chk("t1_cnt", sample_cnt, 1);

        // chained stage results, back to back, including sign wrap
        stub_mode = 1'b1;
        send(16'h0000, 1'b1);
        send(16'h7FF0, 1'b1);
        send(16'h8000, 1'b1);
        wait_idle("t2_idle");
        chk("t2_cnt", sample_cnt, 4);
        stub_mode = 1'b0;

        // start together with a sample: clear precedes the first job strobe
        start = 1'b1; in_valid = 1'b1; in_data = 16'h0F0F; exp_q.push_back(model(16'h0F0F));
        step();
        start = 1'b0; in_valid = 1'b0;
        chk("sc_clear", eng_clear, 1'b1);
        chk("sc_nostart", eng_start, 1'b0);
        step();
        chk("sc_clear_end", eng_clear, 1'b0);
        chk("sc_start", eng_start, 1'b1);
        start = 1'b1; step(); start = 1'b0;
        chk("busy_start_ignored", eng_clear, 1'b0);
        wait_idle("sc_idle");
        chk("sc_cnt", sample_cnt, 1);

        // program stage 0; last write lands together with the sample
        cfg_write(3'd0, 3'd0, 16'h0FF8);
        chk("cfg_ok_b0", cfg_err, 1'b0);
        cfg_write(3'd0, 3'd1, 16'hEDF1);
        cfg_write(3'd0, 3'd3, 16'hE128);
        jobs.delete();
        cfg_we = 1'b1; cfg_stage = 3'd0; cfg_sel = 3'd4; cfg_wdata = 16'h1F1B;
        in_valid = 1'b1; in_data = 16'h0100; exp_q.push_back(model(16'h0100));
        step();
        cfg_we = 1'b0; in_valid = 1'b0;
        chk("cfg_ok_a2", cfg_err, 1'b0);
        wait_idle("cfg_idle");
        chk("cfg_j0_b0", jobs[0].b0, 16'h0FF8);
        chk("cfg_j0_b1", jobs[0].b1, 16'hEDF1);
        chk("cfg_j0_b2", jobs[0].b2, 16'h0000);
        chk("cfg_j0_a1", jobs[0].a1, 16'hE128);
        chk("cfg_j0_a2", jobs[0].a2, 16'h1F1B);
        chk("cfg_j1_b0", jobs[1].b0, 16'h2000);
        chk("cfg_j1_b1", jobs[1].b1, 16'h0000);
        chk("cfg_j5_b0", jobs[5].b0, 16'h2000);
        chk("cfg_j5_a1", jobs[5].a1, 16'h0000);

        // rejected writes: while busy, bad stage, bad select
        send(16'h0202, 1'b1);
        step();
        cfg_write(3'd0, 3'd0, 16'h1111);
        chk("cfg_busy_err", cfg_err, 1'b1);
        step();
        chk("cfg_busy_err_end", cfg_err, 1'b0);
        wait_idle("cfgerr_idle");
        cfg_write(3'd6, 3'd0, 16'h3333);
        chk("cfg_stage_err", cfg_err, 1'b1);
        cfg_write(3'd0, 3'd5, 16'h3333);
        chk("cfg_sel_err", cfg_err, 1'b1);
        jobs.delete();
        send(16'h0303, 1'b1);
        wait_idle("cfgerr2_idle");
        chk("cfgerr_jobs", jobs.size(), N);
        chk("cfgerr_b0_kept", jobs[0].b0, 16'h0FF8);
        chk("cfgerr_a2_kept", jobs[0].a2, 16'h1F1B);

        // engine timeout
        stub_en = 1'b0;
        jobs.delete();
        cnt0 = sample_cnt;
        send(16'h0404, 1'b0);
        n = 0;
        while (!timeout_err && n < 200) begin step(); n++; end
        chk("to_seen", timeout_err, 1'b1);
        chk("to_latency", cyc - acc_cyc, TO + 1);
        chk("to_busy", busy, 1'b0);
        chk("to_in_ready", in_ready, 1'b1);
        chk("to_out_valid", out_valid, 1'b0);
        chk("to_cnt", sample_cnt, cnt0);
        chk("to_jobs", jobs.size(), 1);
        step();
        chk("to_pulse_end", timeout_err, 1'b0);

        // eng_done on the last allowed WAIT cycle wins over the timeout
        send(16'h0505, 1'b1);
        for (int k = 0; k < TO; k++) step();
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        stub_en  = 1'b1;
        chk("edge_no_timeout", timeout_err, 1'b0);
        chk("edge_busy", busy, 1'b1);
        wait_idle("edge_idle");

        // output backpressure
        out_ready = 1'b0;
        hold_x = 16'h5A5A;
        send(hold_x, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin step(); n++; end
        chk("bp_valid", out_valid, 1'b1);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_data !== hold_x || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        chk("bp_stable", stable, 1'b1);
        chk("bp_in_ready", in_ready, 1'b0);
        cnt0 = sample_cnt;
        out_ready = 1'b1;
        step();
        chk("bp_cnt_inc", sample_cnt, cnt0 + 1'b1);
        chk("bp_valid_drop", out_valid, 1'b0);
        step();
        chk("bp_cnt_once", sample_cnt, cnt0 + 1'b1);

        // reset during stage 3 WAIT
        send(16'h0606, 1'b0);
        n = 0;
        while (!(eng_start && eng_stage == 3'd3) && n < 100) begin step(); n++; end
        chk("mr_reached", eng_stage, 3);
        rst_n = 1'b0;
        step();
        chk("mr_busy", busy, 1'b0);
        chk("mr_in_ready", in_ready, 1'b1);
        chk("mr_eng_start", eng_start, 1'b0);
        chk("mr_eng_stage", eng_stage, 0);
        chk("mr_eng_x", eng_x, 0);
        chk("mr_eng_b0", eng_b0, 0);
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_out_data", out_data, 0);
        chk("mr_cnt", sample_cnt, 0);
        rst_n = 1'b1;
        step();
        chk("mr_no_out", out_valid, 1'b0);
        jobs.delete();
        send(16'h4321, 1'b1);
        wait_idle("mr_idle");
        chk("mr_bank_b0", jobs[0].b0, 16'h2000);
        chk("mr_bank_b1", jobs[0].b1, 16'h0000);
        chk("mr_bank_a1", jobs[0].a1, 16'h0000);
        chk("mr_bank_a2", jobs[0].a2, 16'h0000);
        start = 1'b1; step(); start = 1'b0;
        chk("mr_clear", eng_clear, 1'b1);
        chk("mr_clear_cnt", sample_cnt, 0);

        // sample counter wrap
        for (int k = 0; k < (1 << CW) - 1; k++) send(16'(k), 1'b1);
        wait_idle("wrap_idle1");
        chk("wrap_max", sample_cnt, (1 << CW) - 1);
        send(16'hABCD, 1'b1);
        wait_idle("wrap_idle2");
        chk("wrap_zero", sample_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
